// File: rtl/matrix_input_parser.sv
// -----------------------------------------------------------------------------
// matrix_input_parser
//
// Parses an ASCII-decimal byte stream "m n e0 e1 ... e(m*n-1)" coming from the
// UART receiver into matrix dimensions and elements. Elements are written
// row-major into matrix storage starting at a base address supplied with the
// start pulse. A one-cycle done pulse reports completion together with a
// status code.
//
// Ports
//   clk          in   1   system clock
//   rst_n        in   1   asynchronous active-low reset
//   w_en_input   in   1   start pulse; ignored while a parse is in progress
//   i_base_addr  in   8   storage base address, sampled on an accepted start
//   i_rx_valid   in   1   one-cycle strobe, i_rx_data holds a new byte
//   i_rx_data    in   8   received byte
//   o_wr_en      out  1   storage write strobe, one cycle per element
//   o_wr_addr    out  8   storage write address (holds between strobes)
//   o_wr_data    out  32  element value, zero-extended (holds between strobes)
//   o_in_m       out  32  parsed row count, held until the next accepted start
//   o_in_n       out  32  parsed column count, held until the next accepted start
//   o_busy       out  1   high from accepted start until the done cycle
//   o_in_done    out  1   one-cycle completion pulse
//   o_in_err     out  2   0 ok, 1 bad dimension, 2 element out of range,
//                         3 illegal character; held until the next start
// -----------------------------------------------------------------------------
module matrix_input_parser #(
    parameter int MAX_DIM  = 5,
    parameter int ELEM_MAX = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        w_en_input,
    input  logic [7:0]  i_base_addr,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_wr_en,
    output logic [7:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [31:0] o_in_m,
    output logic [31:0] o_in_n,
    output logic        o_busy,
    output logic        o_in_done,
    output logic [1:0]  o_in_err
);

    localparam logic [7:0] MAX_DIM_B  = 8'(MAX_DIM);
    localparam logic [7:0] ELEM_MAX_B = 8'(ELEM_MAX);

    localparam logic [1:0] ERR_DIM  = 2'd1;
    localparam logic [1:0] ERR_ELEM = 2'd2;
    localparam logic [1:0] ERR_CHAR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        GET_M,
        GET_N,
        GET_ELEM,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t     state, state_next;

    logic [7:0] base_q;
    logic [7:0] acc_q;
    logic       have_digit_q;   // current token holds at least one digit
    logic [7:0] m_q;
    logic [7:0] n_q;
    logic [7:0] idx_q;
    logic [7:0] total_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [1:0] err_q;

    logic        is_digit;
    logic        is_sep;
    logic        parsing;
    logic        rx_take;
    logic        tok_end;
    logic        bad_char;
    logic        start_ok;
    logic [11:0] acc_wide;
    logic [7:0]  acc_sat;
    logic        dim_ok;
    logic        elem_ok;
    logic        last_elem;
    logic        err_set;
    logic [1:0]  err_code;

    // -------------------------------------------------------------------------
    // Byte classification and accumulator arithmetic
    // -------------------------------------------------------------------------
    assign is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
    assign is_sep   = (i_rx_data == 8'h20) || (i_rx_data == 8'h0D) ||
                      (i_rx_data == 8'h0A);

    // Bytes only matter while a token is being looked for; in IDLE and in the
    // single-cycle WRITE/DONE/ERR states they are dropped.
    assign parsing  = (state == GET_M) || (state == GET_N) || (state == GET_ELEM);
    assign rx_take  = parsing && i_rx_valid;

    // A separator only closes a token once a digit has been seen, so runs of
    // separators and leading separators collapse to nothing.
    assign tok_end  = rx_take && is_sep && have_digit_q;
    assign bad_char = rx_take && !is_digit && !is_sep;
    assign start_ok = (state == IDLE) && w_en_input;

    // 255*10+9 = 2559 fits in 12 bits, so the saturation test is exact.
    assign acc_wide = ({4'd0, acc_q} * 12'd10) + {8'd0, i_rx_data[3:0]};
    assign acc_sat  = (acc_wide > 12'd255) ? 8'hFF : acc_wide[7:0];

    assign dim_ok    = (acc_q >= 8'd1) && (acc_q <= MAX_DIM_B);
    assign elem_ok   = (acc_q <= ELEM_MAX_B);
    assign last_elem = (idx_q == (total_q - 8'd1));

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers update from the same pre-edge values, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and error decode
    // -------------------------------------------------------------------------
    // NOTE: defaults are assigned first so no path leaves a signal unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        err_code   = 2'd0;

        unique case (state)
            IDLE: begin
                if (w_en_input) begin
                    state_next = GET_M;
                end
            end

            GET_M, GET_N: begin
                if (bad_char) begin
                    err_set    = 1'b1;
                    err_code   = ERR_CHAR;
                    state_next = ERR;
                end else if (tok_end) begin
                    if (!dim_ok) begin
                        err_set    = 1'b1;
                        err_code   = ERR_DIM;
                        state_next = ERR;
                    end else begin
                        state_next = (state == GET_M) ? GET_N : GET_ELEM;
                    end
                end
            end

            GET_ELEM: begin
                if (bad_char) begin
                    err_set    = 1'b1;
                    err_code   = ERR_CHAR;
                    state_next = ERR;
                end else if (tok_end) begin
                    if (!elem_ok) begin
                        err_set    = 1'b1;
                        err_code   = ERR_ELEM;
                        state_next = ERR;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end

            WRITE: begin
                state_next = last_elem ? DONE : GET_ELEM;
            end

            DONE, ERR: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: accumulator, dimensions, element index, write port, status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= 8'd0;
            acc_q        <= 8'd0;
            have_digit_q <= 1'b0;
            m_q          <= 8'd0;
            n_q          <= 8'd0;
            idx_q        <= 8'd0;
            total_q      <= 8'd0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= 8'd0;
            err_q        <= 2'd0;
        end else begin
            if (start_ok) begin
                base_q       <= i_base_addr;
                acc_q        <= 8'd0;
                have_digit_q <= 1'b0;
                m_q          <= 8'd0;
                n_q          <= 8'd0;
                idx_q        <= 8'd0;
                total_q      <= 8'd0;
                err_q        <= 2'd0;
            end

            if (rx_take && is_digit) begin
                acc_q        <= acc_sat;
                have_digit_q <= 1'b1;
            end

            if (tok_end) begin
                acc_q        <= 8'd0;
                have_digit_q <= 1'b0;

                if (state == GET_M && dim_ok) begin
                    m_q <= acc_q;
                end

                if (state == GET_N && dim_ok) begin
                    n_q     <= acc_q;
                    total_q <= m_q * acc_q;
                    idx_q   <= 8'd0;
                end

                // Address and data are registered here so they are stable for
                // the whole WRITE cycle and hold afterwards.
                if (state == GET_ELEM && elem_ok) begin
                    wr_addr_q <= base_q + idx_q;
                    wr_data_q <= acc_q;
                end
            end

            if (state == WRITE) begin
                idx_q <= idx_q + 8'd1;
            end

            if (err_set) begin
                err_q <= err_code;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_wr_en   = (state == WRITE);
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = {24'd0, wr_data_q};
    assign o_in_m    = {24'd0, m_q};
    assign o_in_n    = {24'd0, n_q};
    assign o_busy    = parsing || (state == WRITE);
    assign o_in_done = (state == DONE) || (state == ERR);
    assign o_in_err  = err_q;

endmodule
